// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed driver for a NUM_DIGITS-digit common-anode
//               seven-segment display. Hex nibbles are captured on a load
//               strobe, held pending, and promoted to the display register
//               only at the end of a scan frame so a frame never mixes old
//               and new values. One digit is lit at a time; all outputs are
//               registered.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               value            - 4*NUM_DIGITS hex nibbles (nibble 0 = rightmost)
//               load             - one-cycle capture strobe for value/masks
//               blank_mask       - 1 = digit dark (anode still driven)
//               dp_mask          - 1 = decimal point lit
//               seg, dp          - active-low segments {A..G} and point
//               an               - active-low anode selects
//               digit_idx        - index of the digit shown on an
//               frame_start      - pulse when digit 0 of a new frame shows
// Options     : SEVEN_SEG_LZ_SUPPRESS_EN - leading-zero suppression
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  // Active-low glyphs, bit order {A,B,C,D,E,F,G}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick, boundary;
  logic [NUM_DIGITS-1:0]   dark_mask;
  logic [3:0]              sel_nib;
  logic                    sel_dark, sel_dp;

  // Scan timing and frame-synchronous display update.
  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;

    if (load && boundary) begin
      // Bypass: a load landing on the boundary goes straight to display.
      disp_val_d   = value;
      disp_blank_d = blank_mask;
      disp_dp_d    = dp_mask;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_blank_d = pend_blank_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
  end

  // Digits that must be dark: blank mask, optionally ORed with the
  // leading-zero mask derived from the display register.
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  nz_seen;
  always_comb begin
    lz_mask = '0;
    nz_seen = 1'b0;
    // Walk from the top digit down; a digit is suppressed until the first
    // nonzero nibble is seen. Digit 0 is never included.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_seen    = nz_seen | (|disp_val_q[4*i +: 4]);
      lz_mask[i] = ~nz_seen;
    end
    dark_mask = disp_blank_q | lz_mask;
  end
`else
  always_comb begin
    dark_mask = disp_blank_q;
  end
`endif

  // Select the current digit's fields and form the next registered outputs.
  always_comb begin
    sel_nib  = 4'h0;
    sel_dark = 1'b0;
    sel_dp   = 1'b0;
    an_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib  = disp_val_q[4*i +: 4];
        sel_dark = dark_mask[i];
        sel_dp   = disp_dp_q[i];
        an_d[i]  = 1'b0;
      end
    end
    seg_d         = sel_dark ? 7'b1111111 : glyph(sel_nib);
    dp_d          = sel_dark | ~sel_dp;
    digit_idx_d   = idx_q;
    // First cycle of digit 0 is the first cycle of a frame (also true
    // right after reset, since both counters restart at zero).
    frame_start_d = (idx_q == '0) && (presc_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pend_val_q    <= '0;
      pend_blank_q  <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      disp_val_q    <= '0;
      disp_blank_q  <= '0;
      disp_dp_q     <= '0;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= '1;
      digit_idx_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pend_val_q    <= pend_val_d;
      pend_blank_q  <= pend_blank_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      disp_val_q    <= disp_val_d;
      disp_blank_q  <= disp_blank_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      digit_idx_q   <= digit_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign digit_idx   = digit_idx_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment display; hex value in, one digit lit at a time.
- Per-digit hex-to-segment decode (0-F glyphs), refresh prescaler, digit scan counter and anode select.
- Frame-synchronous (tear-free) value update, per-digit blanking and decimal points.
- Sits between datapath result registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1-8.
- REFRESH_DIV, 50000, clocks each digit stays lit; must be >= 1; prescaler width = max(1, clog2(REFRESH_DIV)).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- value  input  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 = rightmost)
- load  input  1  one-cycle strobe capturing value, blank_mask, dp_mask
- blank_mask  input  NUM_DIGITS  1 = digit i dark
- dp_mask  input  NUM_DIGITS  1 = decimal point of digit i lit
- seg  output  7  segments {A,B,C,D,E,F,G}, active-low
- dp  output  1  decimal point, active-low
- an  output  NUM_DIGITS  anode selects, active-low, at most one low
- digit_idx  output  max(1,clog2(NUM_DIGITS))  index of digit currently on an
- frame_start  output  1  one-cycle pulse when the scan returns to digit 0

Behaviour:
- Reset (sync, active-high): all of the following are cleared on the clock edge while reset = 1.
  - Prescaler = 0, scan index = 0.
  - Pending and display registers = 0; pending_valid = 0.
  - Outputs forced: seg = 7'b1111111, dp = 1, an = all 1s, digit_idx = 0, frame_start = 0.
  - Reset asserted mid-scan or mid-update discards any pending load.
- Prescaler: counts 0..REFRESH_DIV-1; tick = (count == REFRESH_DIV-1); on tick, count wraps to 0.
  - REFRESH_DIV = 1 gives a tick every cycle.
- Scan index: advances on tick and wraps NUM_DIGITS-1 -> 0.
  - Boundary = tick while index == NUM_DIGITS-1.
  - NUM_DIGITS = 1: every tick is a boundary; index stays 0.
- Load capture: load = 1 copies value/blank_mask/dp_mask into the pending register and sets pending_valid.
  - A later load before the boundary overwrites pending (last load wins).
- Display update only at boundary:
  - load and boundary in the same cycle: the new inputs go straight to the display register (bypass); pending_valid cleared.
  - Otherwise, pending_valid at boundary: pending copied to display; pending_valid cleared.
  - Otherwise: display holds.
  - Update takes effect from digit 0 of the next frame; a frame never mixes old and new values.
- Glyph table (active-low, {A..G}):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Outputs: registered, one cycle after the index/display state they reflect.
  - an = ~(1 << index).
  - seg = glyph(nibble[index]), or 1111111 if blank_mask[index].
  - dp = ~dp_mask[index], forced 1 if blank_mask[index].
  - A blanked digit keeps its anode driven (uniform duty cycle).
- frame_start: high for exactly one cycle, the same cycle an first shows digit 0 of a new frame.
  - Also pulses on the first cycle after reset release.
- Timing: first cycle after reset release shows digit 0 of display register 0 (seg = 0000001, an = ...1110).

Optional Feature:
- Macro: SEVEN_SEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digits above the most significant nonzero nibble are dark (seg = 1111111, dp = 1); digit 0 is never suppressed. Suppression is computed from the display register and is ORed with blank_mask.
- Undefined: zeros are displayed normally; no extra logic is synthesised.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, reset 3 cycles then release -> an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; seg = 0000001 throughout; frame_start pulses every 16 cycles, first on cycle 1 after release.
- load value=16'hA5C3 while digit 1 lit -> rest of current frame shows 0; from the next frame start digits 0-3 show 0000110, 0110001, 0100100, 0001000.
- load 16'h1111 then 16'h2222 in the same frame, then load 16'h3333 exactly on the boundary cycle -> the next frame shows 3 (0000110) on all digits; 1 and 2 never appear.
- blank_mask=4'b0100, dp_mask=4'b0101, value 16'h8888 -> digit 2 seg = 1111111, dp = 1 with an2 still low; digit 0 dp = 0; digits 1 and 3 dp = 1.
- Assert reset while digit 2 lit with a load pending -> the next cycle all outputs are in reset state; after release shows 0 on digit 0, and the pending value never appears.
- With SEVEN_SEG_LZ_SUPPRESS_EN, value 16'h0070 -> digits 3-2 dark, digit 1 = 0001111, digit 0 = 0000001; value 16'h0000 -> only digit 0 shows 0000001.
